fft_256_r2: RTL and testbench

// 256-point complex radix-2 DIT FFT/IFFT, memory-based (in-place), one butterfly per cycle.

---
 rtl/fft_256_r2.sv | 238 +++++++++++++++++++++++
 tb/tb_fft_256_r2.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_256_r2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_256_r2 : 256-point radix-2 DIT FFT/IFFT, in-place, 1 butterfly/cycle  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fft_256_r2 #(
   parameter int N  = 256,
   parameter int DW = 16,
   parameter int TW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inv,
   input  logic                 valid_in,
   input  logic                 sop_in,
   input  logic signed [DW-1:0] x_re,
   input  logic signed [DW-1:0] x_im,
   output logic                 valid_out,
   output logic                 sop_out,
   output logic signed [DW-1:0] y_re,
   output logic signed [DW-1:0] y_im
);

   localparam int PW  = DW + TW + 1;
   localparam int TWW = DW + 2;
   localparam int SW  = DW + 3;
   localparam logic [7:0] LAST = 8'(N - 1);

   // cos(2*pi*i/256) in Q1.15, i = 0..63
   localparam logic signed [TW-1:0] COS_Q [64] = '{
      16'sd32767, 16'sd32757, 16'sd32728, 16'sd32678, 16'sd32609, 16'sd32521, 16'sd32412, 16'sd32285,
      16'sd32137, 16'sd31971, 16'sd31785, 16'sd31580, 16'sd31356, 16'sd31113, 16'sd30852, 16'sd30571,
      16'sd30273, 16'sd29956, 16'sd29621, 16'sd29268, 16'sd28898, 16'sd28510, 16'sd28105, 16'sd27683,
      16'sd27245, 16'sd26790, 16'sd26319, 16'sd25832, 16'sd25329, 16'sd24811, 16'sd24279, 16'sd23731,
      16'sd23170, 16'sd22594, 16'sd22005, 16'sd21403, 16'sd20787, 16'sd20159, 16'sd19519, 16'sd18868,
      16'sd18204, 16'sd17530, 16'sd16846, 16'sd16151, 16'sd15446, 16'sd14732, 16'sd14010, 16'sd13279,
      16'sd12539, 16'sd11793, 16'sd11039, 16'sd10278, 16'sd9512,  16'sd8739,  16'sd7962,  16'sd7179,
      16'sd6393,  16'sd5602,  16'sd4808,  16'sd4011,  16'sd3212,  16'sd2410,  16'sd1608,  16'sd804
   };

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMPUTE = 2'd2, OUTPUT = 2'd3} state_t;
   state_t state, state_nx;

   function automatic logic [7:0] bitrev(input logic [7:0] v);
      return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
   endfunction

   logic signed [DW-1:0] mem_re [N];
   logic signed [DW-1:0] mem_im [N];

   logic [7:0] cnt;
   logic       inv_lat;
   logic [2:0] stage;
   logic [6:0] bfly;
   logic       draining, drain_cnt;
   logic       load_we, start, issue, stage_done;
   logic [7:0] load_addr;

   logic [6:0]           lo_mask, k, tw_idx;
   logic [7:0]           addr_a, addr_b;
   logic signed [TW-1:0] cos_w, sin_w, sin_eff;

   logic                  p1_valid, p1_bypass;
   logic signed [DW-1:0]  p1_a_re, p1_a_im, p1_b_re, p1_b_im;
   logic signed [TW-1:0]  p1_cos, p1_sin;
   logic [7:0]            p1_addr_a, p1_addr_b;
   logic                  p2_valid;
   logic signed [DW-1:0]  p2_a_re, p2_a_im;
   logic signed [TWW-1:0] p2_t_re, p2_t_im;
   logic [7:0]            p2_addr_a, p2_addr_b;

   logic signed [PW-1:0]  prod_re, prod_im;
   logic signed [TWW-1:0] t_re, t_im;
   logic signed [SW-1:0]  sum_re, sum_im, dif_re, dif_im;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      load_we    = 1'b0;
      load_addr  = bitrev(cnt);
      start      = 1'b0;
      issue      = 1'b0;
      stage_done = 1'b0;
      case (state)
         IDLE: if (valid_in && sop_in) begin
            load_we   = 1'b1;
            load_addr = '0;
            start     = 1'b1;
            state_nx  = LOAD;
         end
         LOAD: if (valid_in) begin
            load_we = 1'b1;
            if (sop_in) begin
               load_addr = '0;
               start     = 1'b1;
            end else if (cnt == LAST) begin
               state_nx = COMPUTE;
            end
         end
         COMPUTE: begin
            issue = !draining;
            // two idle cycles let the last writes of a stage land before the next stage reads
            if (draining && drain_cnt) begin
               stage_done = 1'b1;
               if (stage == 3'd7) state_nx = OUTPUT;
            end
         end
         OUTPUT: if (cnt == LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         inv_lat   <= 1'b0;
         stage     <= '0;
         bfly      <= '0;
         draining  <= 1'b0;
         drain_cnt <= 1'b0;
      end else begin
         if (start) begin
            cnt     <= 8'd1;
            inv_lat <= inv;
         end else if ((state == LOAD && valid_in) || state == OUTPUT) begin
            cnt <= cnt + 8'd1;
         end
         if (issue) begin
            bfly <= bfly + 7'd1;
            if (bfly == 7'h7F) draining <= 1'b1;
         end
         if (draining) drain_cnt <= 1'b1;
         if (stage_done) begin
            draining  <= 1'b0;
            drain_cnt <= 1'b0;
            stage     <= stage + 3'd1;
         end
      end
   end

   // butterfly addressing and quarter-wave twiddle lookup
   always_comb begin
      lo_mask = ~(7'h7F << stage);
      k       = bfly & lo_mask;
      addr_a  = {bfly & ~lo_mask, 1'b0} | {1'b0, k};
      addr_b  = addr_a | (8'd1 << stage);
      tw_idx  = k << (3'd7 - stage);
      if (!tw_idx[6])              cos_w = COS_Q[tw_idx[5:0]];
      else if (tw_idx[5:0] == '0)  cos_w = '0;
      else                         cos_w = -COS_Q[6'd0 - tw_idx[5:0]];
      if (tw_idx == '0)            sin_w = '0;
      else if (!tw_idx[6])         sin_w = COS_Q[6'd0 - tw_idx[5:0]];
      else                         sin_w = COS_Q[tw_idx[5:0]];
      sin_eff = inv_lat ? -sin_w : sin_w;
   end

   // W = 1 bypasses the multiplier so trivial rotations stay exact
   always_comb begin
      prod_re = PW'(p1_b_re) * PW'(p1_cos) + PW'(p1_b_im) * PW'(p1_sin);
      prod_im = PW'(p1_b_im) * PW'(p1_cos) - PW'(p1_b_re) * PW'(p1_sin);
      t_re    = p1_bypass ? TWW'(p1_b_re) : TWW'(prod_re >>> (TW - 1));
      t_im    = p1_bypass ? TWW'(p1_b_im) : TWW'(prod_im >>> (TW - 1));
      sum_re  = SW'(p2_a_re) + SW'(p2_t_re);
      sum_im  = SW'(p2_a_im) + SW'(p2_t_im);
      dif_re  = SW'(p2_a_re) - SW'(p2_t_re);
      dif_im  = SW'(p2_a_im) - SW'(p2_t_im);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_valid <= 1'b0;
         p2_valid <= 1'b0;
      end else begin
         p1_valid <= issue;
         p2_valid <= p1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) begin
         p1_a_re   <= mem_re[addr_a];
         p1_a_im   <= mem_im[addr_a];
         p1_b_re   <= mem_re[addr_b];
         p1_b_im   <= mem_im[addr_b];
         p1_cos    <= cos_w;
         p1_sin    <= sin_eff;
         p1_bypass <= (tw_idx == '0);
         p1_addr_a <= addr_a;
         p1_addr_b <= addr_b;
      end
      if (p1_valid) begin
         p2_a_re   <= p1_a_re;
         p2_a_im   <= p1_a_im;
         p2_t_re   <= t_re;
         p2_t_im   <= t_im;
         p2_addr_a <= p1_addr_a;
         p2_addr_b <= p1_addr_b;
      end
   end

   always_ff @(posedge clk) begin
      if (load_we) begin
         mem_re[load_addr] <= x_re;
         mem_im[load_addr] <= x_im;
      end
      if (p2_valid) begin
         mem_re[p2_addr_a] <= DW'(sum_re >>> 1);
         mem_im[p2_addr_a] <= DW'(sum_im >>> 1);
         mem_re[p2_addr_b] <= DW'(dif_re >>> 1);
         mem_im[p2_addr_b] <= DW'(dif_im >>> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out <= 1'b0;
         sop_out   <= 1'b0;
         y_re      <= '0;
         y_im      <= '0;
      end else if (state == OUTPUT) begin
         valid_out <= 1'b1;
         sop_out   <= (cnt == '0);
         y_re      <= mem_re[cnt];
         y_im      <= mem_im[cnt];
      end else begin
         valid_out <= 1'b0;
         sop_out   <= 1'b0;
         y_re      <= '0;
         y_im      <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_256_r2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fft_256_r2 : directed frame vectors and reset corner cases            |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_fft_256_r2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               inv = 1'b0;
   logic               valid_in = 1'b0;
   logic               sop_in = 1'b0;
   logic signed [15:0] x_re = '0;
   logic signed [15:0] x_im = '0;
   logic               valid_out, sop_out;
   logic signed [15:0] y_re, y_im;

   fft_256_r2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inv       (inv),
      .valid_in  (valid_in),
      .sop_in    (sop_in),
      .x_re      (x_re),
      .x_im      (x_im),
      .valid_out (valid_out),
      .sop_out   (sop_out),
      .y_re      (y_re),
      .y_im      (y_im)
   );

   always #5 clk = ~clk;

   localparam int P_IMP  = 0;
   localparam int P_DC   = 1;
   localparam int P_RAMP = 2;
   localparam int P_TONE = 3;

   typedef struct {
      int pat;
      bit inv_v;
      bit gaps;
      bit toggle;
      bit restart;
      bit junk;
      int bin;
      int exp_re;
      int exp_im;
      int tol;
      bit all;
      int oth_re;
      int oth_im;
   } vec_t;

   vec_t vecs[8];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cap_re[256];
   int   cap_im[256];
   int   n_valid, n_sop, sop_idx, lat;

   task automatic check(input string name, input bit ok, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, req);
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic int samp(input int pat, input int n);
      case (pat)
         P_IMP:   return (n == 0) ? 256 : 0;
         P_DC:    return 256;
         P_RAMP:  return 256 - n;
         default: return (n == 1) ? 16384 : 0;
      endcase
   endfunction

   task automatic drive_frame(input int pat, input bit inv_v, input bit gaps, input bit toggle);
      for (int n = 0; n < 256; n++) begin
         if (gaps && (n % 50 == 7)) begin
            repeat (3) begin
               @(negedge clk);
               valid_in = 1'b0;
               sop_in   = 1'b0;
               inv      = ~inv_v;
               x_re     = 16'sh7fff;
               x_im     = -16'sd1;
            end
         end
         @(negedge clk);
         valid_in = 1'b1;
         sop_in   = (n == 0);
         inv      = (n == 0) ? inv_v : (toggle ? ~inv_v : inv_v);
         x_re     = 16'(samp(pat, n));
         x_im     = (pat == P_RAMP) ? 16'(samp(pat, n)) : 16'sd0;
      end
      @(negedge clk);
      valid_in = 1'b0;
      sop_in   = 1'b0;
      x_re     = '0;
      x_im     = '0;
   endtask

   task automatic collect(input string tag, input bit junk);
      lat = 0; n_valid = 0; n_sop = 0; sop_idx = -1;
      while (!valid_out && lat < 1500) begin
         if (junk) begin
            valid_in = 1'b1;
            sop_in   = 1'b1;
            inv      = 1'($urandom);
            x_re     = 16'($urandom);
            x_im     = 16'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      valid_in = 1'b0;
      sop_in   = 1'b0;
      check({tag, " latency"}, lat <= 1400, lat, 1400);
      while (valid_out && n_valid < 300) begin
         if (n_valid < 256) begin
            cap_re[n_valid] = y_re;
            cap_im[n_valid] = y_im;
         end
         if (sop_out) begin
            n_sop++;
            if (sop_idx < 0) sop_idx = n_valid;
         end
         n_valid++;
         @(negedge clk);
      end
      check({tag, " valid count"}, n_valid == 256, n_valid, 256);
      check({tag, " sop position"}, n_sop == 1 && sop_idx == 0, sop_idx, 0);
   endtask

   task automatic verify(input string tag, input vec_t v);
      int bad, first;
      check({tag, " bin re"}, absd(cap_re[v.bin], v.exp_re) <= v.tol, cap_re[v.bin], v.exp_re);
      check({tag, " bin im"}, absd(cap_im[v.bin], v.exp_im) <= v.tol, cap_im[v.bin], v.exp_im);
      if (v.all) begin
         bad = 0; first = -1;
         for (int b = 0; b < 256; b++) begin
            if (b != v.bin && (cap_re[b] != v.oth_re || cap_im[b] != v.oth_im)) begin
               bad++;
               if (first < 0) first = b;
            end
         end
         check($sformatf("%s other bins (first bad bin %0d)", tag, first), bad == 0, bad, 0);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      if (v.restart) begin
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            valid_in = 1'b1;
            sop_in   = (n == 0);
            inv      = ~v.inv_v;
            x_re     = 16'sd256;
            x_im     = 16'sd100;
         end
      end
      drive_frame(v.pat, v.inv_v, v.gaps, v.toggle);
      collect(tag, v.junk);
      verify(tag, v);
   endtask

   initial begin
      int   seen;
      vec_t dc;
      //            pat     inv   gaps  tog   rst   junk  bin re   im   tol all  ore oim
      vecs[0] = '{P_IMP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1,   0,   0, 1'b1, 1, 0};
      vecs[1] = '{P_DC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  256, 0,   0, 1'b1, 0, 0};
      vecs[2] = '{P_RAMP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  128, 128, 2, 1'b0, 0, 0};
      vecs[3] = '{P_TONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64, 0,   -64, 1, 1'b0, 0, 0};
      vecs[4] = '{P_TONE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64, 0,   64,  1, 1'b0, 0, 0};
      vecs[5] = '{P_IMP,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  1,   0,   0, 1'b1, 1, 0};
      vecs[6] = '{P_TONE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64, 0,   -64, 1, 1'b0, 0, 0};
      vecs[7] = '{P_TONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64, 0,   -64, 1, 1'b0, 0, 0};
      dc = vecs[1];

      repeat (3) @(negedge clk);
      check("reset valid_out", valid_out == 1'b0, int'(valid_out), 0);
      check("reset sop_out", sop_out == 1'b0, int'(sop_out), 0);
      check("reset y", y_re == 0 && y_im == 0, int'(y_re), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // reset while the butterflies are running aborts the frame
      drive_frame(P_DC, 1'b0, 1'b0, 1'b0);
      repeat (300) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst in compute valid_out", valid_out == 1'b0, int'(valid_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (1500) begin
         @(negedge clk);
         if (valid_out) seen++;
      end
      check("rst in compute no output", seen == 0, seen, 0);
      drive_frame(P_DC, 1'b0, 1'b0, 1'b0);
      collect("post-reset dc", 1'b0);
      verify("post-reset dc", dc);

      // reset while streaming clears outputs without waiting for a clock edge
      drive_frame(P_IMP, 1'b0, 1'b0, 1'b0);
      lat = 0;
      while (!valid_out && lat < 1500) begin
         @(negedge clk);
         lat++;
      end
      check("rst in output stream started", valid_out == 1'b1, int'(valid_out), 1);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst in output valid_out async", valid_out == 1'b0, int'(valid_out), 0);
      check("rst in output y async", y_re == 0 && y_im == 0, int'(y_re), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (valid_out) seen++;
      end
      check("rst in output no resume", seen == 0, seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
